// File: rtl/lsu_wb_gather_ctrl.sv
// Sequencer for the LSU memory-to-writeback gather shift register: collects tagged
// memory words, pads with zero shifts to a full vector, then hands off to writeback.
module lsu_wb_gather_ctrl #(
    parameter int NUM_LANES = 64,
    parameter int TAG_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic [6:0]       issue_words,
    input  logic             mem_ack,
    input  logic [TAG_W-1:0] mem_tag,
    output logic             load_wb,
    output logic             pad_sel,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic             stray_ack
);

    localparam logic [6:0] LANES = 7'(NUM_LANES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PAD     = 2'd2,
        WB      = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [6:0]       word_cnt, word_cnt_n;
    logic [6:0]       shift_cnt, shift_cnt_n;
    logic [TAG_W-1:0] cur_tag, cur_tag_n;
    logic [6:0]       words_clamped;
    logic             good_ack;
    logic             stray;

    assign words_clamped = (issue_words > LANES) ? LANES : issue_words;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            word_cnt  <= '0;
            shift_cnt <= '0;
            cur_tag   <= '0;
            stray_ack <= 1'b0;
        end else begin
            state     <= state_n;
            word_cnt  <= word_cnt_n;
            shift_cnt <= shift_cnt_n;
            cur_tag   <= cur_tag_n;
            stray_ack <= stray;
        end
    end

    always_comb begin
        state_n     = state;
        word_cnt_n  = word_cnt;
        shift_cnt_n = shift_cnt;
        cur_tag_n   = cur_tag;
        issue_ready = 1'b0;
        load_wb     = 1'b0;
        pad_sel     = 1'b0;
        wb_valid    = 1'b0;
        wb_tag      = '0;
        good_ack    = 1'b0;
        unique case (state)
            IDLE: begin
                issue_ready = 1'b1;
                if (issue_valid) begin
                    cur_tag_n   = issue_tag;
                    shift_cnt_n = '0;
                    word_cnt_n  = words_clamped;
                    state_n     = (words_clamped != 7'd0) ? COLLECT : PAD;
                end
            end
            COLLECT: begin
                if (mem_ack && mem_tag == cur_tag) begin
                    good_ack    = 1'b1;
                    load_wb     = 1'b1;
                    word_cnt_n  = word_cnt - 7'd1;
                    shift_cnt_n = shift_cnt + 7'd1;
                    if (word_cnt == 7'd1)
                        state_n = (shift_cnt + 7'd1 == LANES) ? WB : PAD;
                end
            end
            PAD: begin
                // zero shifts push the collected words down so word i ends in lane i
                load_wb     = 1'b1;
                pad_sel     = 1'b1;
                shift_cnt_n = shift_cnt + 7'd1;
                if (shift_cnt + 7'd1 == LANES)
                    state_n = WB;
            end
            WB: begin
                wb_valid = 1'b1;
                wb_tag   = cur_tag;
                if (wb_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // any ack not consumed as a good collect word is reported one cycle later
    assign stray = mem_ack & ~good_ack;

endmodule

// File: tb/tb_lsu_wb_gather_ctrl.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor models the
// gather register and checks each writeback handshake against the queue.
module tb_lsu_wb_gather_ctrl;

    localparam int NL = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [6:0]  issue_tag = '0;
    logic [6:0]  issue_words = '0;
    logic        mem_ack = 1'b0;
    logic [6:0]  mem_tag = '0;
    logic [31:0] mem_data = '0;
    logic        load_wb, pad_sel, wb_valid, stray_ack;
    logic        wb_ready = 1'b0;
    logic [6:0]  wb_tag;

    lsu_wb_gather_ctrl #(.NUM_LANES(NL), .TAG_W(7)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_tag(issue_tag), .issue_words(issue_words),
        .mem_ack(mem_ack), .mem_tag(mem_tag),
        .load_wb(load_wb), .pad_sel(pad_sel),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
        .stray_ack(stray_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]            tag;
        int                    lat;
        int                    nreal;
        logic [NL-1:0][31:0]   lanes;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int real_cnt = 0;
    int pad_cnt = 0;
    int lat = 0;
    int stray_seen = 0;
    bit in_wb = 0;
    bit hold_bad = 0;
    logic [NL-1:0][31:0] gr = '0;
    logic [NL-1:0][31:0] snap = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: external gather register model plus writeback scoreboard
    always @(negedge clk) begin
        exp_t e;
        int bad;
        if (stray_ack) stray_seen++;
        if (load_wb) begin
            gr = {(pad_sel ? 32'h0 : mem_data), gr[NL-1:1]};
            if (pad_sel) pad_cnt++; else real_cnt++;
        end
        if (rst && issue_valid && issue_ready) begin
            acc_cyc  = cyc + 1;
            real_cnt = 0;
            pad_cnt  = 0;
        end
        if (!rst) begin
            in_wb = 0;
            hold_bad = 0;
        end else if (wb_valid) begin
            if (!in_wb) begin
                in_wb = 1;
                lat   = cyc - acc_cyc;
                snap  = gr;
            end else if (gr !== snap || load_wb) begin
                hold_bad = 1;
            end
            if (wb_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: got result tag %0h want none", wb_tag);
                end else begin
                    e = sb.pop_front();
                    chk("wb_tag", 32'(wb_tag), 32'(e.tag));
                    chk("wb_latency", 32'(lat), 32'(e.lat));
                    chk("real_shifts", 32'(real_cnt), 32'(e.nreal));
                    chk("pad_shifts", 32'(pad_cnt), 32'(NL - e.nreal));
                    chk("wb_hold_stable", 32'(hold_bad), 32'd0);
                    bad = 0;
                    for (int i = NL - 1; i >= 0; i--)
                        if (gr[i] !== e.lanes[i]) bad = i;
                    chk($sformatf("lane%0d", bad), gr[bad], e.lanes[bad]);
                end
                in_wb = 0;
                hold_bad = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [6:0] t, input int l, input int n, input logic [31:0] base);
        exp_t e;
        e.tag = t;
        e.lat = l;
        e.nreal = n;
        e.lanes = '0;
        for (int i = 0; i < n; i++) e.lanes[i] = base + 32'(i);
        sb.push_back(e);
    endtask

    task automatic issue(input logic [6:0] t, input logic [6:0] n);
        issue_valid = 1'b1;
        issue_tag   = t;
        issue_words = n;
        step();
        issue_valid = 1'b0;
    endtask

    task automatic ack(input logic [6:0] t, input logic [31:0] d);
        mem_ack  = 1'b1;
        mem_tag  = t;
        mem_data = d;
        step();
        mem_ack  = 1'b0;
    endtask

    // ack expected to be ignored; consumes the ack cycle plus one more
    task automatic stray(input logic [6:0] t);
        ack(t, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("stray_pulse", 32'(stray_ack), 32'd1);
        step();
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 300 && !wb_valid; k++) step();
        if (!wb_valid) begin
            checks++;
            failures++;
            $display("FAIL wb_timeout: got wb_valid 0 want 1");
        end
    endtask

    task automatic wait_wb(input int hold);
        wait_valid();
        repeat (hold) step();
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
    endtask

    task automatic chk_reset_outs(input string pfx);
        chk({pfx, "_issue_ready"}, 32'(issue_ready), 32'd1);
        chk({pfx, "_load_wb"}, 32'(load_wb), 32'd0);
        chk({pfx, "_pad_sel"}, 32'(pad_sel), 32'd0);
        chk({pfx, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({pfx, "_wb_tag"}, 32'(wb_tag), 32'd0);
        chk({pfx, "_stray_ack"}, 32'(stray_ack), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        chk_reset_outs("rst");
        rst = 1'b1;
        step();

        // full 64-word load, held 3 cycles before wb_ready
        push_exp(7'h15, 64, 64, 32'h0);
        issue(7'h15, 7'd64);
        for (int i = 0; i < 64; i++) ack(7'h15, 32'(i));
        wait_wb(3);
        step();

        // partial load
        push_exp(7'h2A, 64, 4, 32'hA0);
        issue(7'h2A, 7'd4);
        for (int i = 0; i < 4; i++) ack(7'h2A, 32'hA0 + 32'(i));
        wait_wb(0);
        step();

        // gapped acks with a mismatched tag; five non-good cycles before the last word
        push_exp(7'h22, 69, 3, 32'h300);
        issue(7'h22, 7'd3);
        ack(7'h22, 32'h300);
        step();
        step();
        stray(7'h7F);
        ack(7'h22, 32'h301);
        step();
        ack(7'h22, 32'h302);
        wait_wb(0);
        step();

        // N=0: pure padding, an ack during PAD is stray
        push_exp(7'h01, 64, 0, 32'h0);
        issue(7'h01, 7'd0);
        repeat (5) step();
        stray(7'h01);
        wait_wb(0);
        step();

        // N=100 clamps to 64; writeback stall with next issue held high
        push_exp(7'h33, 64, 64, 32'h1000);
        push_exp(7'h44, 64, 2, 32'h5000);
        issue(7'h33, 7'd100);
        for (int i = 0; i < 64; i++) ack(7'h33, 32'h1000 + 32'(i));
        wait_valid();
        issue_valid = 1'b1;
        issue_tag   = 7'h44;
        issue_words = 7'd2;
        for (int i = 0; i < 10; i++) begin
            if (i == 0 || i == 9) chk("stall_issue_ready", 32'(issue_ready), 32'd0);
            step();
        end
        stray(7'h33);
        chk("stall_wb_valid", 32'(wb_valid), 32'd1);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("idle_after_wb", 32'(issue_ready), 32'd1);
        step();
        issue_valid = 1'b0;
        chk("collect_not_ready", 32'(issue_ready), 32'd0);
        ack(7'h44, 32'h5000);
        ack(7'h44, 32'h5001);
        wait_wb(0);
        step();

        // reset after 20 acks of a 64-word load
        issue(7'h55, 7'd64);
        for (int i = 0; i < 20; i++) ack(7'h55, 32'(i));
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk_reset_outs("midrst");
        mem_ack = 1'b1;
        mem_tag = 7'h55;
        #2;
        chk("post_rst_no_load", 32'(load_wb), 32'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("post_rst_stray", 32'(stray_ack), 32'd1);
        step();
        chk("post_rst_idle", 32'(issue_ready), 32'd1);
        chk("stray_pulse_end", 32'(stray_ack), 32'd0);
        repeat (3) step();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("stray_total", 32'(stray_seen), 32'd4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_wb_gather_ctrl.md
# lsu_wb_gather_ctrl

Sequencing controller for the LSU memory-to-writeback gather register, a 2048-bit shift flop that takes one 32-bit memory word per `load_wb` pulse at the top and shifts toward lane 0. It accepts one load at a time from LSU issue and counts tagged memory acks, driving `load_wb` for each accepted word. It then pads the remaining lanes with zero shifts so that word i lands in lane i, and presents the completed 64-lane result to the VGPR/SGPR writeback port under a valid/ready handshake.

## Interface
- `NUM_LANES`, 64: shift-register depth in 32-bit words. Must match the gather register.
- `TAG_W`, 7: memory tag width.
- `clk` input 1: single clock. All state updates on its rising edge.
- `rst` input 1: synchronous, active-low reset. `rst==0` at a rising edge resets the block.
- `issue_valid` input 1: new load request.
- `issue_ready` output 1: controller idle; request accepted when `issue_valid & issue_ready`.
- `issue_tag` input TAG_W: tag expected on returning acks.
- `issue_words` input 7: number of real words to collect (0..64).
- `mem_ack` input 1: memory returns one word this cycle, same cycle as the data.
- `mem_tag` input TAG_W: tag of the returning word.
- `load_wb` output 1: shift-enable to the gather register. Combinational, same cycle.
- `pad_sel` output 1: selects zero into the gather register data input instead of memory data.
- `wb_valid` output 1: gather register holds a complete result.
- `wb_ready` input 1: writeback consumer takes the result.
- `wb_tag` output TAG_W: tag of the result being written back.
- `stray_ack` output 1: registered one-cycle pulse for an ack that was ignored.

## Operation
- States: IDLE, COLLECT, PAD, WB. Internal registers: 7-bit `word_cnt` (words remaining), 7-bit `shift_cnt` (total shifts done), `cur_tag`.
- IDLE:
  - `issue_ready=1`.
  - On accept, latch `cur_tag=issue_tag` and clear `shift_cnt`.
  - Load `word_cnt=min(issue_words,64)`; values above 64 clamp to 64.
  - Next state is COLLECT if `word_cnt != 0`, else PAD.
- COLLECT:
  - A good ack is `mem_ack & mem_tag==cur_tag`. A good ack sets `load_wb=1` and `pad_sel=0`, decrements `word_cnt`, and increments `shift_cnt`.
  - The last good ack goes to WB if `shift_cnt+1==64`, else to PAD.
- PAD:
  - `load_wb=1`, `pad_sel=1` every cycle, incrementing `shift_cnt`.
  - The shift that brings `shift_cnt` to 64 transitions to WB.
- WB:
  - `wb_valid=1`, `wb_tag=cur_tag`, `load_wb=0`. The register contents are frozen.
  - `wb_valid & wb_ready` goes to IDLE.
- Stray ack: `mem_ack` in IDLE, PAD, or WB, or with a tag mismatch in COLLECT. The word is not loaded, no counter changes, and `stray_ack` pulses the following cycle.
- Every result is exactly 64 shifts: lane i holds real word i for i<N and zero for i≥N.

## Timing
- Reset values:
  - state IDLE.
  - `issue_ready=1`, `load_wb=0`, `pad_sel=0`, `wb_valid=0`, `wb_tag=0`, `stray_ack=0`.
  - Counters 0.
- Reset mid-operation abandons the load immediately. Acks arriving after reset are stray.
- Accept at edge E: COLLECT (or PAD) is active in cycle E+1.
- Latency with N≥1 and acks back-to-back from cycle E+1: `wb_valid` first high in cycle E+65, independent of N. Gaps in acks add cycles 1:1.
- N=0: 64 PAD cycles, then `wb_valid` in cycle E+65.
- `wb_valid` holds until `wb_ready` is sampled high. The result is consumed at that edge and the next cycle is IDLE.
- Back-to-back loads: at least one IDLE cycle between WB and the next COLLECT. `issue_ready` is low in COLLECT, PAD, and WB.
- `load_wb` and `pad_sel` are never both driven from a memory ack and a pad in the same cycle.
- `stray_ack` has one-cycle latency and a one-cycle width per stray ack.

## Test plan
- Full vector load:
  - Stimulus: issue tag 0x15, N=64, then 64 consecutive acks with tag 0x15 and data=lane index.
  - Required: 64 `load_wb` pulses with `pad_sel=0`; `wb_valid` in cycle E+65 with `wb_tag=0x15`; lane i=i; hold until `wb_ready`.
- Partial load:
  - Stimulus: N=4 with acks carrying data 0xA0..0xA3.
  - Required: 4 real shifts, then 60 PAD cycles; lanes 0..3 = 0xA0..0xA3, lanes 4..63 = 0; `wb_valid` at E+65.
- Gapped and mismatched acks:
  - Stimulus: N=3 with idle gaps, plus one ack tagged 0x7F interleaved.
  - Required: 0x7F is not loaded, `stray_ack` pulses once, and the result is correct and delayed by the gap cycles.
- N=0 and N=100:
  - N=0 required: 64 pad shifts and an all-zero result.
  - N=100 required: clamped to 64 real words, with no PAD state.
- Writeback stall then back-to-back issue:
  - Stimulus: `wb_ready` low for 10 cycles with `issue_valid` held high.
  - Required: `wb_valid` and data stable; `issue_ready` low until the IDLE cycle after `wb_ready`.
- Reset mid-collect:
  - Stimulus: `rst=0` for one cycle after 20 acks of a 64-word load.
  - Required: all outputs return to reset values at the next cycle; a following ack produces only `stray_ack`.
